// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per CALC cycle: shift-add multiply, restoring divide on magnitudes.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [1:0]       op_r;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] acc, quo, dsr;

  logic             neg_a_c, neg_b_c, dz_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH:0]   add_sum, shl_rem, sub_diff;
  logic [WIDTH-1:0] acc_nx, quo_nx, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod;

  // Operand magnitudes; only the signed ops (op[0]==0) treat the MSB as a sign.
  always_comb begin
    neg_a_c = ~op_r[0] & a_r[WIDTH-1];
    neg_b_c = ~op_r[0] & b_r[WIDTH-1];
    mag_a_c = neg_a_c ? -a_r : a_r;
    mag_b_c = neg_b_c ? -b_r : b_r;
  end

  // One iteration: acc holds the upper product half or the partial remainder.
  always_comb begin
    add_sum  = {1'b0, acc} + (quo[0] ? {1'b0, dsr} : '0);
    shl_rem  = {acc, quo[WIDTH-1]};
    sub_diff = shl_rem - {1'b0, dsr};
    acc_nx   = add_sum[WIDTH:1];
    quo_nx   = {add_sum[0], quo[WIDTH-1:1]};
    if (op_r[1]) begin
      if (!sub_diff[WIDTH]) begin
        acc_nx = sub_diff[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = shl_rem[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction: quotient sign is the XOR of operand signs, remainder follows the dividend.
  always_comb begin
    prod  = {acc, quo};
    if (neg_a ^ neg_b) prod = -prod;
    q_fix = (neg_a ^ neg_b) ? -quo : quo;
    r_fix = neg_a ? -acc : acc;
    dz_c  = op_r[1] & (dsr == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (cnt == CW'(WIDTH)) next_state = FIXUP;
      FIXUP:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // First CALC cycle (cnt==0) loads magnitudes; cnt 1..WIDTH are the bit iterations.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      acc         <= '0;
      quo         <= '0;
      dsr         <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op;
            cnt  <= '0;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (cnt == '0) begin
            neg_a <= neg_a_c;
            neg_b <= neg_b_c;
            acc   <= '0;
            quo   <= op_r[1] ? mag_a_c : mag_b_c;
            dsr   <= op_r[1] ? mag_b_c : mag_a_c;
          end else begin
            acc <= acc_nx;
            quo <= quo_nx;
          end
        end
        FIXUP: begin
          if (op_r[1]) begin
            if (!dz_c) begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end else begin
            {hi, lo} <= prod;
          end
        end
        default: ;
      endcase
      busy        <= (next_state != IDLE);
      done        <= (state == FIXUP);
      div_by_zero <= (state == FIXUP) & dz_c;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: 32-bit and 8-bit instances against an arithmetic model.
module tb_mult_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, start32, hi_we32, lo_we32, busy32, done32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wdata32, hi32, lo32;
  logic        rst8, start8, hi_we8, lo_we8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8, hi8, lo8;

  mult_div_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst32), .start(start32), .op(op32), .a(a32), .b(b32),
    .hi_we(hi_we32), .lo_we(lo_we32), .wdata(wdata32), .hi(hi32), .lo(lo32),
    .busy(busy32), .done(done32), .div_by_zero(dz32));

  mult_div_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8), .hi(hi8), .lo(lo8),
    .busy(busy8), .done(done8), .div_by_zero(dz8));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
  } exp_t;

  exp_t        q32[$], q8[$];
  exp_t        e32, e8;
  logic [31:0] mhi32, mlo32, mhi8, mlo8;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v, input int w, input bit sgn);
    logic [63:0] u;
    u = 64'(v) & ((64'd1 << w) - 64'd1);
    if (sgn && u[w-1]) u = u - (64'd1 << w);
    return longint'(u);
  endfunction

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] ohi,
                                input logic [31:0] olo, output logic [31:0] nhi,
                                output logic [31:0] nlo, output bit dz);
    longint      sa, sb, p, q, r;
    logic [63:0] m;
    m   = (64'd1 << w) - 64'd1;
    sa  = sx(a, w, !o[0]);
    sb  = sx(b, w, !o[0]);
    dz  = 1'b0;
    nhi = ohi;
    nlo = olo;
    if (!o[1]) begin
      p   = sa * sb;
      nlo = 32'(64'(p) & m);
      nhi = 32'((64'(p) >> w) & m);
    end else if (sb == 0) begin
      dz = 1'b1;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      nlo = 32'(64'(q) & m);
      nhi = 32'(64'(r) & m);
    end
  endfunction

  always @(negedge clk) begin
    if (done32) begin
      if (q32.size() == 0) begin
        total++; bad++;
        $display("FAIL done32_spurious: got done=1 expected no pending op");
      end else begin
        e32 = q32.pop_front();
        chk("hi32", hi32, e32.hi);
        chk("lo32", lo32, e32.lo);
        chk("dz32", dz32, e32.dz);
      end
    end else if (dz32) begin
      total++; bad++;
      $display("FAIL dz32_alone: got 1 expected 0");
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL done8_spurious: got done=1 expected no pending op");
      end else begin
        e8 = q8.pop_front();
        chk("hi8", hi8, e8.hi);
        chk("lo8", lo8, e8.lo);
        chk("dz8", dz8, e8.dz);
      end
    end else if (dz8) begin
      total++; bad++;
      $display("FAIL dz8_alone: got 1 expected 0");
    end
  end

  // mode 0: plain op; 1: start held, lo_we at launch, late operand change and hi_we while busy;
  // 2: reset at cycle 4 of the op.
  task automatic do_op(input bit s8, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int mode);
    int          w, n;
    exp_t        e;
    bit          dz;
    logic [31:0] nh, nl;
    w = s8 ? 8 : 32;
    if (s8) model(w, o, a, b, mhi8, mlo8, nh, nl, dz);
    else    model(w, o, a, b, mhi32, mlo32, nh, nl, dz);
    e.hi = nh; e.lo = nl; e.dz = dz;
    if (s8) begin
      q8.push_back(e); mhi8 = nh; mlo8 = nl;
      op8 = o; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
      lo_we8 = (mode == 1); wdata8 = 8'h5A;
    end else begin
      q32.push_back(e); mhi32 = nh; mlo32 = nl;
      op32 = o; a32 = a; b32 = b; start32 = 1'b1;
      lo_we32 = (mode == 1); wdata32 = 32'h5A5A_5A5A;
    end
    @(posedge clk); #1;
    lo_we8 = 1'b0; lo_we32 = 1'b0;
    if (mode != 1) begin start8 = 1'b0; start32 = 1'b0; end
    n = 0;
    while (!(s8 ? done8 : done32) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("busy_mid", s8 ? busy8 : busy32, 1);
      if (mode == 1 && n == 5) begin
        if (s8) begin op8 = ~o; a8 = ~a[7:0]; b8 = b8 + 8'd1; hi_we8 = 1'b1; wdata8 = 8'hC3; end
        else begin op32 = ~o; a32 = ~a; b32 = b + 32'd1; hi_we32 = 1'b1; wdata32 = 32'hC3C3_C3C3; end
      end
      if (mode == 1 && n == 6) begin hi_we8 = 1'b0; hi_we32 = 1'b0; end
      if (mode == 2 && n == 4) begin
        if (s8) begin e = q8.pop_back(); rst8 = 1'b1; end
        else begin e = q32.pop_back(); rst32 = 1'b1; end
        @(posedge clk); #1;
        rst8 = 1'b0; rst32 = 1'b0;
        chk("abort_busy", s8 ? busy8 : busy32, 0);
        chk("abort_done", s8 ? done8 : done32, 0);
        chk("abort_hi", s8 ? 32'(hi8) : hi32, 0);
        chk("abort_lo", s8 ? 32'(lo8) : lo32, 0);
        if (s8) begin mhi8 = '0; mlo8 = '0; end
        else begin mhi32 = '0; mlo32 = '0; end
        repeat (w + 6) @(posedge clk);
        #1;
        return;
      end
    end
    chk("latency", n, w + 2);
    start8 = 1'b0; start32 = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", s8 ? done8 : done32, 0);
    chk("idle_after_done", s8 ? busy8 : busy32, 0);
  endtask

  task automatic wr(input bit s8, input bit hw, input bit lw, input logic [31:0] d);
    if (s8) begin hi_we8 = hw; lo_we8 = lw; wdata8 = d[7:0]; end
    else begin hi_we32 = hw; lo_we32 = lw; wdata32 = d; end
    @(posedge clk); #1;
    hi_we8 = 1'b0; lo_we8 = 1'b0; hi_we32 = 1'b0; lo_we32 = 1'b0;
    if (s8) begin
      if (hw) mhi8 = {24'd0, d[7:0]};
      if (lw) mlo8 = {24'd0, d[7:0]};
      chk("wr_hi8", hi8, mhi8);
      chk("wr_lo8", lo8, mlo8);
    end else begin
      if (hw) mhi32 = d;
      if (lw) mlo32 = d;
      chk("wr_hi32", hi32, mhi32);
      chk("wr_lo32", lo32, mlo32);
    end
  endtask

  task automatic rand_ops(input bit s8, input int count);
    for (int i = 0; i < count; i++) begin
      logic [1:0]  o;
      logic [31:0] ra, rb;
      o  = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = s8 ? 32'h80 : 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) wr(s8, 1'b1, 1'b1, $urandom);
      do_op(s8, o, ra, rb, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    {start32, hi_we32, lo_we32, op32, a32, b32, wdata32} = '0;
    {start8, hi_we8, lo_we8, op8, a8, b8, wdata8} = '0;
    mhi32 = '0; mlo32 = '0; mhi8 = '0; mlo8 = '0;
    rst32 = 1'b1; rst8 = 1'b1;
    start32 = 1'b1; lo_we32 = 1'b1; wdata32 = 32'h0000_FFFF;
    hi_we8 = 1'b1; wdata8 = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst32 = 1'b0; rst8 = 1'b0;
    start32 = 1'b0; lo_we32 = 1'b0; hi_we8 = 1'b0;
    chk("rst_hi32", hi32, 0);
    chk("rst_lo32", lo32, 0);
    chk("rst_busy32", busy32, 0);
    chk("rst_done32", done32, 0);
    chk("rst_hi8", hi8, 0);
    chk("rst_busy8", busy8, 0);

    do_op(0, 2'b00, 32'd9, 32'hFFFF_FFF5, 0);
    chk("mult_hi", hi32, 32'hFFFF_FFFF);
    chk("mult_lo", lo32, 32'hFFFF_FF9D);
    do_op(0, 2'b01, 32'hFFFF_FFFF, 32'd2, 0);
    chk("multu_hi", hi32, 32'h0000_0001);
    chk("multu_lo", lo32, 32'hFFFF_FFFE);
    do_op(0, 2'b11, 32'hFFFF_FFFF, 32'd2, 0);
    chk("divu_lo", lo32, 32'h7FFF_FFFF);
    chk("divu_hi", hi32, 32'h0000_0001);
    do_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_lo", lo32, 32'hFFFF_FFFD);
    chk("div_hi", hi32, 32'hFFFF_FFFF);
    do_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_wrap_lo", lo32, 32'h8000_0000);
    chk("div_wrap_hi", hi32, 32'h0);
    wr(0, 1'b0, 1'b1, 32'h1234);
    do_op(0, 2'b11, 32'd5, 32'd0, 0);
    chk("dz_lo_kept", lo32, 32'h1234);
    do_op(0, 2'b00, $urandom, $urandom, 1);
    wr(0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    rand_ops(0, 30);

    do_op(1, 2'b00, 32'h80, 32'h80, 0);
    chk("mult8_hi", hi8, 8'h40);
    chk("mult8_lo", lo8, 8'h00);
    do_op(1, 2'b01, $urandom, $urandom, 2);
    do_op(1, 2'b10, $urandom, $urandom, 1);
    rand_ops(1, 30);

    repeat (5) @(posedge clk);
    #1;
    chk("q32_drained", q32.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
